// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state type for the memory-access stage
package mem_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_GNT,
      ST_WAIT_RVALID,
      ST_HOLD
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and misalignment detection
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Access size comes from funct3[1:0]; loads and stores share the lane pattern.
   always_comb begin
      be    = 4'b1111;
      wdata = st_data;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ld_data = {24'b0, byte_sel};
         F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ld_data = {16'b0, half_sel};
         default: ld_data = rdata;
      endcase
   end

   assign misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && addr_lo[0])
                     || (funct3 == F3_LW && addr_lo != 2'b00);

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory stage: req/gnt/rvalid data-memory access and write-back select
module mem_stage_lsu
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       PC_i,
   input  logic [31:0]       inst_i,
   input  logic [31:0]       alu_out_i,
   input  logic [31:0]       dataR2_i,
   input  logic              regWEn_i,
   input  logic              memRW_i,
   input  logic [1:0]        wb_sel_i,
   input  logic [2:0]        ld_st_sel_i,
   input  logic [31:0]       pc_plus_four_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic              stall_o,
   output logic              misalign_o,
   output logic [31:0]       PC_o,
   output logic [31:0]       inst_o,
   output logic              regWEn_o,
   output logic [31:0]       wb_data_o
);

   lsu_state_t  state;
   logic [31:0] ld_cap;
   logic        is_store, is_load, is_mem;
   logic [3:0]  be_a;
   logic [31:0] ld_ext;
   logic        mis;

   lsu_align u_align (
      .funct3     (ld_st_sel_i),
      .addr_lo    (alu_out_i[1:0]),
      .st_data    (dataR2_i),
      .rdata      (dmem_rdata_i),
      .be         (be_a),
      .wdata      (dmem_wdata_o),
      .ld_data    (ld_ext),
      .misaligned (mis)
   );

   assign is_store = memRW_i;
   assign is_load  = !memRW_i && (wb_sel_i == WB_MEM);
   assign is_mem   = is_store || is_load;

   // Outputs are combinational from state so a granted store costs no stall cycle.
   always_comb begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_mem) begin
               if (mis) begin
                  misalign_o = 1'b1;
               end else begin
                  dmem_req_o = 1'b1;
                  stall_o    = is_load || !dmem_gnt_i;
               end
            end
         end
         ST_WAIT_GNT: begin
            dmem_req_o = 1'b1;
            stall_o    = is_load || !dmem_gnt_i;
         end
         ST_WAIT_RVALID: stall_o = 1'b1;
         default: ;
      endcase
   end

   assign dmem_we_o   = dmem_req_o && is_store;
   assign dmem_be_o   = dmem_req_o ? be_a : 4'b0000;
   assign dmem_addr_o = {alu_out_i[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         ld_cap <= 32'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_mem && !mis) begin
                  if (!dmem_gnt_i)
                     state <= ST_WAIT_GNT;
                  else if (is_load)
                     state <= ST_WAIT_RVALID;
               end
            end
            ST_WAIT_GNT: begin
               if (dmem_gnt_i)
                  state <= is_load ? ST_WAIT_RVALID : ST_IDLE;
            end
            ST_WAIT_RVALID: begin
               if (dmem_rvalid_i) begin
                  ld_cap <= ld_ext;
                  state  <= ST_HOLD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      case (wb_sel_i)
         WB_MEM:  wb_data_o = ld_cap;
         WB_PC4:  wb_data_o = pc_plus_four_i;
         default: wb_data_o = alu_out_i;
      endcase
   end

   // A stalled cycle is bubbled into MEM/WB, so it must not write the register file.
   assign regWEn_o = regWEn_i && !stall_o && !misalign_o;
   assign PC_o     = PC_i;
   assign inst_o   = inst_i;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_i, inst_i, alu_out_i, dataR2_i, pc_plus_four_i;
   logic        regWEn_i, memRW_i;
   logic [1:0]  wb_sel_i;
   logic [2:0]  ld_st_sel_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o, misalign_o, regWEn_o;
   logic [31:0] PC_o, inst_o, wb_data_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.ADDR_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .PC_i           (PC_i),
      .inst_i         (inst_i),
      .alu_out_i      (alu_out_i),
      .dataR2_i       (dataR2_i),
      .regWEn_i       (regWEn_i),
      .memRW_i        (memRW_i),
      .wb_sel_i       (wb_sel_i),
      .ld_st_sel_i    (ld_st_sel_i),
      .pc_plus_four_i (pc_plus_four_i),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_be_o      (dmem_be_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_gnt_i     (dmem_gnt_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .stall_o        (stall_o),
      .misalign_o     (misalign_o),
      .PC_o           (PC_o),
      .inst_o         (inst_o),
      .regWEn_o       (regWEn_o),
      .wb_data_o      (wb_data_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      memRW_i       = 1'b0;
      wb_sel_i      = 2'b00;
      regWEn_i      = 1'b0;
      ld_st_sel_i   = 3'b000;
      alu_out_i     = 32'h0000_1234;
      dataR2_i      = 32'h0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
   endtask

   task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic gnt);
      memRW_i     = 1'b0;
      wb_sel_i    = 2'b01;
      regWEn_i    = 1'b1;
      ld_st_sel_i = f3;
      alu_out_i   = addr;
      dmem_gnt_i  = gnt;
   endtask

   // Load with immediate grant and rvalid one cycle later; checks the HOLD value.
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
      set_load(f3, addr, 1'b1);
      @(negedge clk);
      chk({tag, "_req"}, 32'(dmem_req_o), 32'd1);
      chk({tag, "_stall1"}, 32'(stall_o), 32'd1);
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      @(negedge clk);
      chk({tag, "_req_wait"}, 32'(dmem_req_o), 32'd0);
      chk({tag, "_stall2"}, 32'(stall_o), 32'd1);
      tick();
      dmem_rvalid_i = 1'b0;
      @(negedge clk);
      chk({tag, "_stall_hold"}, 32'(stall_o), 32'd0);
      chk({tag, "_wb"}, wb_data_o, exp);
      chk({tag, "_we"}, 32'(regWEn_o), 32'd1);
      tick();
      set_nop();
   endtask

   initial begin
      reset          = 1'b1;
      PC_i           = 32'h0000_1000;
      inst_i         = 32'h0000_0013;
      pc_plus_four_i = 32'h0000_1004;
      set_nop();
      tick();
      tick();
      @(negedge clk);
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_be", 32'(dmem_be_o), 32'd0);
      chk("rst_wb", wb_data_o, 32'h0000_1234);
      chk("pc_pass", PC_o, 32'h0000_1000);
      chk("inst_pass", inst_o, 32'h0000_0013);
      tick();
      reset = 1'b0;

      // SB 0xA5 to 0x103 with grant in the same cycle
      memRW_i = 1'b1; ld_st_sel_i = 3'b000; alu_out_i = 32'h103;
      dataR2_i = 32'h0000_00A5; dmem_gnt_i = 1'b1;
      @(negedge clk);
      chk("sb_req", 32'(dmem_req_o), 32'd1);
      chk("sb_we", 32'(dmem_we_o), 32'd1);
      chk("sb_be", 32'(dmem_be_o), 32'h8);
      chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
      chk("sb_addr", dmem_addr_o, 32'h100);
      chk("sb_stall", 32'(stall_o), 32'd0);
      tick();
      set_nop();
      @(negedge clk);
      chk("sb_single_req", 32'(dmem_req_o), 32'd0);
      chk("sb_single_we", 32'(dmem_we_o), 32'd0);
      tick();

      run_load("lb", 3'b000, 32'h101, 32'h0000_8000, 32'hFFFF_FF80);
      run_load("lbu", 3'b100, 32'h101, 32'h0000_8000, 32'h0000_0080);
      run_load("lh", 3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
      run_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001);

      // SW with grant delayed three cycles
      memRW_i = 1'b1; ld_st_sel_i = 3'b010; alu_out_i = 32'h200;
      dataR2_i = 32'hDEAD_BEEF; dmem_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dmem_gnt_i = (i == 3);
         @(negedge clk);
         chk($sformatf("sw_req%0d", i), 32'(dmem_req_o), 32'd1);
         chk($sformatf("sw_addr%0d", i), dmem_addr_o, 32'h200);
         chk($sformatf("sw_be%0d", i), 32'(dmem_be_o), 32'hF);
         chk($sformatf("sw_wdata%0d", i), dmem_wdata_o, 32'hDEAD_BEEF);
         chk($sformatf("sw_stall%0d", i), 32'(stall_o), (i == 3) ? 32'd0 : 32'd1);
         tick();
      end
      set_nop();
      @(negedge clk);
      chk("sw_done_req", 32'(dmem_req_o), 32'd0);
      tick();

      // SH upper half
      memRW_i = 1'b1; ld_st_sel_i = 3'b001; alu_out_i = 32'h306;
      dataR2_i = 32'h1234_BEEF; dmem_gnt_i = 1'b1;
      @(negedge clk);
      chk("sh_be", 32'(dmem_be_o), 32'hC);
      chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
      tick();
      set_nop();

      // LW misaligned
      set_load(3'b010, 32'h102, 1'b1);
      @(negedge clk);
      chk("mis_flag", 32'(misalign_o), 32'd1);
      chk("mis_req", 32'(dmem_req_o), 32'd0);
      chk("mis_we", 32'(regWEn_o), 32'd0);
      chk("mis_stall", 32'(stall_o), 32'd0);
      tick();
      set_nop();
      @(negedge clk);
      chk("mis_pulse_end", 32'(misalign_o), 32'd0);
      tick();

      // JAL-type write-back of PC+4, unsolicited rvalid in IDLE
      wb_sel_i = 2'b10; regWEn_i = 1'b1; pc_plus_four_i = 32'h2004;
      dmem_rvalid_i = 1'b1;
      @(negedge clk);
      chk("jal_wb", wb_data_o, 32'h2004);
      chk("jal_req", 32'(dmem_req_o), 32'd0);
      chk("jal_we", 32'(regWEn_o), 32'd1);
      chk("jal_stall", 32'(stall_o), 32'd0);
      tick();
      set_nop();

      // Reset while waiting for rvalid
      set_load(3'b010, 32'h300, 1'b1);
      tick();
      dmem_gnt_i = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_stall_pre", 32'(stall_o), 32'd1);
      tick();
      reset = 1'b0;
      set_nop();
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h5555_5555;
      @(negedge clk);
      chk("rstmid_stall", 32'(stall_o), 32'd0);
      chk("rstmid_req", 32'(dmem_req_o), 32'd0);
      tick();
      dmem_rvalid_i = 1'b0;
      set_load(3'b010, 32'h400, 1'b0);
      @(negedge clk);
      chk("rstmid_no_hold_req", 32'(dmem_req_o), 32'd1);
      chk("rstmid_no_hold_stall", 32'(stall_o), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_nop();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
